// File: rtl/s4ga_cfg_seq.sv
// s4ga_cfg_seq: configuration sequencer for an N-LUT S4GA fabric.
// Holds one configuration frame in a small segment memory. On a command it
// either clears the fabric and then streams frames back to back, or streams a
// single frame. Memory layout per LUT n: K index fields of IDX_SEGS segments
// each, then the truth-table mask of MASK_SEGS segments; every field is
// stored most-significant segment first.
module s4ga_cfg_seq #(
    parameter int unsigned N    = 16,
    parameter int unsigned K    = 4,
    parameter int unsigned SI_W = 4,
    localparam int unsigned IDX_SEGS   = ($clog2(N) + SI_W - 1) / SI_W,
    localparam int unsigned MASK_SEGS  = ((2 ** K) + SI_W - 1) / SI_W,
    localparam int unsigned LUT_SEGS   = K * IDX_SEGS + MASK_SEGS,
    localparam int unsigned FRAME_SEGS = N * LUT_SEGS,
    localparam int unsigned A_W        = $clog2(FRAME_SEGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [A_W-1:0]  cfg_addr,
    input  logic [SI_W-1:0] cfg_data,
    input  logic            start,
    input  logic            step,
    input  logic            halt,
    output logic [SI_W-1:0] si,
    output logic            lut_rst,
    output logic            busy,
    output logic            frame_done,
    output logic [7:0]      frame_cnt,
    output logic            cfg_err
);

    // Clear-cycle counter spans 0..N-1.
    localparam int unsigned C_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [C_W-1:0] C_LAST   = C_W'(N - 1);
    localparam logic [A_W-1:0] P_FIRST  = '0;
    localparam logic [A_W-1:0] P_LAST   = A_W'(FRAME_SEGS - 1);
    // A one-segment frame ends on the very cycle it starts.
    localparam bit             ONE_SEG  = (FRAME_SEGS == 1);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun,
        StStep1
    } state_e;

    state_e          state_q;
    logic [A_W-1:0]  p_q;
    logic [C_W-1:0]  clr_cnt_q;
    logic            halt_pend_q;
    logic [SI_W-1:0] mem [FRAME_SEGS];

    logic [A_W-1:0]  p_inc;
    logic            frame_end;
    logic            addr_ok;

    assign p_inc     = p_q + A_W'(1);
    assign frame_end = (p_q == P_LAST);
    assign addr_ok   = (32'(cfg_addr) < FRAME_SEGS);
    assign busy      = (state_q != StIdle);

    // Config memory write port: only accepted while idle; never touched by reset
    // but a simultaneous reset still blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && cfg_we && (state_q == StIdle) && addr_ok) begin
            mem[cfg_addr] <= cfg_data;
        end
    end

    // Sequencer FSM; si/lut_rst/frame_done/frame_cnt/cfg_err are all registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            p_q         <= '0;
            clr_cnt_q   <= '0;
            halt_pend_q <= 1'b0;
            si          <= '0;
            lut_rst     <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            cfg_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            cfg_err    <= cfg_we && (state_q != StIdle);

            unique case (state_q)
                StIdle: begin
                    p_q         <= '0;
                    clr_cnt_q   <= '0;
                    halt_pend_q <= 1'b0;
                    si          <= '0;
                    lut_rst     <= 1'b0;
                    // start wins over step; halt has no meaning here.
                    if (start) begin
                        state_q <= StClear;
                        lut_rst <= 1'b1;
                    end else if (step) begin
                        state_q    <= StStep1;
                        si         <= mem[P_FIRST];
                        frame_done <= ONE_SEG;
                    end
                end

                StClear: begin
                    // lut_rst is already high for clear cycle clr_cnt_q.
                    if (clr_cnt_q == C_LAST) begin
                        state_q    <= StRun;
                        lut_rst    <= 1'b0;
                        p_q        <= '0;
                        si         <= mem[P_FIRST];
                        frame_done <= ONE_SEG;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + C_W'(1);
                    end
                end

                StRun, StStep1: begin
                    if (frame_end) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        // A halt arriving on the last segment still lands on this boundary.
                        if ((state_q == StStep1) || halt_pend_q || halt) begin
                            state_q     <= StIdle;
                            p_q         <= '0;
                            si          <= '0;
                            halt_pend_q <= 1'b0;
                        end else begin
                            p_q        <= '0;
                            si         <= mem[P_FIRST];
                            frame_done <= ONE_SEG;
                        end
                    end else begin
                        p_q        <= p_inc;
                        si         <= mem[p_inc];
                        frame_done <= (p_inc == P_LAST);
                        if ((state_q == StRun) && halt) begin
                            halt_pend_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/s4ga_cfg_seq.md
S4GA_CFG_SEQ -- requirements
Module: s4ga_cfg_seq

Interface
REQ-001 Parameter N, default 16: number of LUTs in the driven fabric.
REQ-002 Parameter K, default 4: LUT inputs per LUT.
REQ-003 Parameter SI_W, default 4: segment width streamed per clock.
REQ-004 Derived constants:
  - IDX_SEGS = ceil(clog2(N)/SI_W)
  - MASK_SEGS = ceil(2**K/SI_W)
  - LUT_SEGS = K*IDX_SEGS + MASK_SEGS
  - FRAME_SEGS = N*LUT_SEGS
  - A_W = clog2(FRAME_SEGS)
  - Defaults give 1, 4, 8, 128 and 7.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cfg_we  in  1  config memory write strobe.
REQ-008 cfg_addr  in  A_W  config segment address.
REQ-009 cfg_data  in  SI_W  config segment data.
REQ-010 start  in  1  command: clear fabric, then stream frames continuously.
REQ-011 step  in  1  command: stream exactly one frame, with no clear.
REQ-012 halt  in  1  command: stop at the next frame boundary.
REQ-013 si  out  SI_W  segment stream to the fabric; registered.
REQ-014 lut_rst  out  1  fabric reset; registered.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 frame_done  out  1  one-cycle pulse on the last segment of each frame.
REQ-017 frame_cnt  out  8  completed-frame counter; wraps 255->0.
REQ-018 cfg_err  out  1  one-cycle pulse when a write is rejected.

Function
REQ-019 Config memory shall hold FRAME_SEGS entries of SI_W bits, with one write port and one read port.
REQ-020 Segment order within the memory shall be:
  - per LUT n = 0..N-1: K index fields, each IDX_SEGS segments, most-significant segment first;
  - then the mask, MASK_SEGS segments, most-significant segment first.
REQ-021 States shall be IDLE, CLEAR, RUN and STEP1.
REQ-022 In IDLE, cfg_we=1 shall write cfg_data to mem[cfg_addr] at the clock edge.
REQ-023 In any other state, cfg_we=1 shall leave memory unchanged and pulse cfg_err in the next cycle.
REQ-024 IDLE + start shall go to CLEAR. IDLE + step without start shall go to STEP1. start wins if both are high.
REQ-025 CLEAR shall drive lut_rst=1 and si=0 for exactly N consecutive output cycles, then go to RUN.
REQ-026 RUN and STEP1 shall drive lut_rst=0 and si=mem[p] for p = 0,1,...,FRAME_SEGS-1, one segment per cycle, gap-free.
REQ-027 The first streamed segment shall be output in the cycle immediately after the last lut_rst=1 cycle.
REQ-028 On the output cycle carrying p = FRAME_SEGS-1:
  - frame_done=1;
  - frame_cnt increments in the following cycle.
REQ-029 At the end of a RUN frame with no halt pending, p shall wrap to 0 and the next frame shall begin in the next cycle, with no CLEAR and no bubble.
REQ-030 halt sampled high during RUN shall set a pending flag; the current frame shall complete and then the state goes to IDLE.
REQ-031 halt shall be ignored in IDLE and CLEAR.
REQ-032 STEP1 shall return to IDLE after one frame, regardless of halt.
REQ-033 start and step shall be ignored while busy. halt has priority over a simultaneous start.
REQ-034 In IDLE, outputs shall be si=0 and lut_rst=0, and p shall be held at 0.
REQ-035 Output latency from a command edge to the first lut_rst=1 or first segment output shall be exactly 1 cycle.

Reset
REQ-036 rst=1 shall force, at the next edge:
  - state IDLE, p=0, halt-pending=0;
  - si=0, lut_rst=0, busy=0, frame_done=0, frame_cnt=0, cfg_err=0.
REQ-037 rst mid-CLEAR or mid-frame shall abort immediately, with no frame_done and no frame_cnt increment.
REQ-038 Config memory contents shall not be affected by rst.
REQ-039 rst shall take priority over all commands and writes in the same cycle.

Verification
REQ-040 Write mem[i] = i mod 16 for i = 0..127, then pulse step.
  - Required: si = 0,1,...,15,0,... for 128 cycles; lut_rst=0 throughout; frame_done on the cycle si=15 at p=127; frame_cnt=1; then IDLE with busy=0.
REQ-041 Pulse start.
  - Required: lut_rst=1 for 16 cycles; then 3 back-to-back frames with no gap.
  - Pulse halt at cycle 50 of frame 3: the frame finishes and frame_cnt=3.
REQ-042 Issue cfg_we during RUN.
  - Required: cfg_err pulses and memory is unchanged; verify by a subsequent step readback.
REQ-043 Assert rst at p=60 of a RUN frame.
  - Required: the next cycle has busy=0, si=0, frame_cnt=0, and no frame_done.
REQ-044 Assert start and step together in IDLE, then halt and start together during RUN.
  - Required: CLEAR entered in the first case; halt honoured and start ignored in the second.
REQ-045 Run 256 frames with start.
  - Required: frame_cnt wraps to 0 and streaming continues uninterrupted.
